// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, constants and entry layout for the fetch stage.
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t      ZERO_WORD        = '0;
  localparam logic       ENABLE           = 1'b1;
  localparam logic       DISABLE          = 1'b0;
  localparam inst_addr_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam inst_addr_t PC_STEP          = 32'd4;

  function automatic inst_addr_t next_pc(input inst_addr_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - synchronous instruction-buffer FIFO (module fetch_fifo).
// A clear may coincide with a push; the pushed word then becomes the only entry.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    wr_idx;
  logic             pop_ok;

  assign pop_ok = pop & ~empty;
  assign wr_idx = clear ? '0 : wr_ptr;
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PW'(1) : '0;
      count  <= push ? CNT_W'(1) : '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch: PC, credit-limited imem requests, response buffer to decode.
// Optional misaligned-redirect reporting via IF_FETCH_ADEL_CHECK_EN (adds id_adel_o).
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        id_ready_i
`ifdef IF_FETCH_ADEL_CHECK_EN
  ,
  output logic        id_adel_o
`endif
);

  localparam int CW    = $clog2(BUF_DEPTH) + 1;
  localparam int SUM_W = CW + 1;
`ifdef IF_FETCH_ADEL_CHECK_EN
  localparam int ENTRY_W = INST_ADDR_W + INST_W + 1;
`else
  localparam int ENTRY_W = INST_ADDR_W + INST_W;
`endif

  inst_addr_t   fetch_pc;
  inst_addr_t   resp_pc;
  inst_addr_t   flush_target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic          grant;
  logic          credit_ok;
  logic          adel_lock;
  logic          misaligned;
  logic          rsp_keep;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;

`ifdef IF_FETCH_ADEL_CHECK_EN
  assign misaligned   = |flush_pc_i[1:0];
  assign flush_target = flush_pc_i;
  assign push_data    = flush_i ? {1'b1, flush_pc_i, ZERO_WORD}
                                : {1'b0, resp_pc, imem_rdata_i};
`else
  logic unused_flush_lsbs;
  assign unused_flush_lsbs = ^flush_pc_i[1:0];
  assign misaligned        = DISABLE;
  assign flush_target      = {flush_pc_i[31:2], 2'b00};
  assign push_data         = {resp_pc, imem_rdata_i};
`endif

  assign credit_ok   = (SUM_W'(outstanding) + SUM_W'(fifo_count)) < SUM_W'(BUF_DEPTH);
  assign imem_req_o  = ~rst & ~flush_i & ~adel_lock & credit_ok;
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o & imem_gnt_i;

  assign outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid_i);
  assign rsp_keep         = imem_rvalid_i & (drop_cnt == '0);
  assign fifo_push        = flush_i ? misaligned : rsp_keep;
  assign fifo_pop         = id_valid_o & id_ready_i & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      adel_lock   <= DISABLE;
    end else begin
      outstanding <= outstanding_next;
      if (flush_i) begin
        fetch_pc  <= flush_target;
        resp_pc   <= flush_target;
        // Everything still in flight after this edge belongs to the old stream,
        // including responses already marked for discard.
        drop_cnt  <= outstanding_next;
        adel_lock <= misaligned;
      end else begin
        if (grant) begin
          fetch_pc <= next_pc(fetch_pc);
        end
        if (imem_rvalid_i) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CW'(1);
          end else begin
            resp_pc <= next_pc(resp_pc);
          end
        end
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH),
    .CNT_W (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_i),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign id_valid_o = ~fifo_empty;
  assign id_inst_o  = fifo_empty ? ZERO_WORD : head[INST_W-1:0];
  assign id_pc_o    = fifo_empty ? '0 : head[INST_W +: INST_ADDR_W];
`ifdef IF_FETCH_ADEL_CHECK_EN
  assign id_adel_o  = ~fifo_empty & head[ENTRY_W-1];
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized bench for if_fetch against an epoch-tagged queue model.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i;
`ifdef IF_FETCH_ADEL_CHECK_EN
  logic        id_adel_o;
`endif

  always #5 clk = ~clk;

  if_fetch #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_ready_i    (id_ready_i)
`ifdef IF_FETCH_ADEL_CHECK_EN
    ,
    .id_adel_o     (id_adel_o)
`endif
  );

  // Each in-flight request remembers which redirect epoch issued it; decode must
  // only ever see entries of the current epoch, in address order.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ent_t;

  req_t        pend[$];
  ent_t        buf_q[$];
  logic [31:0] m_fetch;
  int          epoch;
  bit          locked;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    buf_q.delete();
    m_fetch = RST_PC;
    epoch   = 0;
    locked  = 1'b0;
  endtask

  task automatic check_outputs(input bit in_rst);
    logic exp_req;
    exp_req = !in_rst && !flush_i && !locked && ((pend.size() + buf_q.size()) < DEPTH);
    check("imem_req", imem_req_o, exp_req);
    check("imem_addr", imem_addr_o, m_fetch);
    check("id_valid", id_valid_o, buf_q.size() != 0);
    if (buf_q.size() != 0) begin
      check("id_pc", id_pc_o, buf_q[0].pc);
      check("id_inst", id_inst_o, buf_q[0].inst);
`ifdef IF_FETCH_ADEL_CHECK_EN
      check("id_adel", id_adel_o, buf_q[0].adel);
`endif
    end else begin
      check("id_pc_empty", id_pc_o, 32'h0);
      check("id_inst_empty", id_inst_o, 32'h0);
`ifdef IF_FETCH_ADEL_CHECK_EN
      check("id_adel_empty", id_adel_o, 32'h0);
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush_i = 1'b0; flush_pc_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; id_ready_i = 1'b0;
    @(negedge clk);
    model_reset();
    check_outputs(1'b1);
    rst = 1'b0;
  endtask

  task automatic step(input int gnt_pct, input int rv_pct, input int rdy_pct, input int fl_pct);
    bit   do_rsp, grant, pop;
    req_t r;
    ent_t e;
    @(negedge clk);
    flush_i    = ($urandom_range(0, 99) < fl_pct);
    flush_pc_i = $urandom & 32'h0000_0FFC;
    if ($urandom_range(0, 9) == 0) flush_pc_i = 32'hFFFF_FFF4;
`ifdef IF_FETCH_ADEL_CHECK_EN
    if ($urandom_range(0, 3) == 0) flush_pc_i[1:0] = 2'($urandom_range(1, 3));
`endif
    imem_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
    do_rsp        = (pend.size() != 0) && ($urandom_range(0, 99) < rv_pct);
    imem_rvalid_i = do_rsp;
    imem_rdata_i  = do_rsp ? mem_word(pend[0].addr) : $urandom;
    id_ready_i    = ($urandom_range(0, 99) < rdy_pct);
    #1;
    check_outputs(1'b0);

    grant = imem_req_o && imem_gnt_i;
    pop   = (buf_q.size() != 0) && id_ready_i;
    if (do_rsp) r = pend.pop_front();
    if (flush_i) begin
      if (grant) begin
        r.addr = m_fetch; r.epoch = epoch; pend.push_back(r);
      end
      buf_q.delete();
      epoch++;
      m_fetch = flush_pc_i;
      locked  = 1'b0;
      if (flush_pc_i[1:0] != 2'b00) begin
        e.pc = flush_pc_i; e.inst = 32'h0; e.adel = 1'b1;
        buf_q.push_back(e);
        locked = 1'b1;
      end
    end else begin
      if (pop) void'(buf_q.pop_front());
      if (do_rsp && r.epoch == epoch) begin
        e.pc = r.addr; e.inst = mem_word(r.addr); e.adel = 1'b0;
        buf_q.push_back(e);
      end
      if (grant) begin
        r.addr = m_fetch; r.epoch = epoch; pend.push_back(r);
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; flush_pc_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; id_ready_i = 1'b0;
    model_reset();
    do_reset();
    for (int i = 0; i < 300; i++) step(100, 100, 100, 0);
    for (int i = 0; i < 500; i++) step(70, 60, 50, 4);
    for (int i = 0; i < 300; i++) step(100, 100, 10, 3);
    // Quiesce memory before a mid-run reset.
    for (int i = 0; i < 20 && pend.size() != 0; i++) step(0, 100, 50, 0);
    check("drain_done", pend.size(), 0);
    do_reset();
    for (int i = 0; i < 500; i++) step(30, 40, 90, 6);
    for (int i = 0; i < 400; i++) step(90, 80, 70, 10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
